// File: rtl/muldiv_sequencer.sv
// Control sequencer for the multiplier/divider: accepts MULT/DIV requests, starts the
// selected unit, waits for completion with a bounded timeout, then loads HI/LO or raises an exception.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic clk,
    input  logic reset_in,
    input  logic req_mult,
    input  logic req_div,
    input  logic mult_stop,
    input  logic div_stop,
    input  logic div_zero,
    output logic mult_init,
    output logic div_init,
    output logic mux_high,
    output logic mux_low,
    output logic high_load,
    output logic low_load,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_exc
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MULT_INIT = 3'd1;
    localparam logic [2:0] MULT_WAIT = 3'd2;
    localparam logic [2:0] DIV_INIT  = 3'd3;
    localparam logic [2:0] DIV_WAIT  = 3'd4;
    localparam logic [2:0] WRITE     = 3'd5;
    localparam logic [2:0] EXC       = 3'd6;

    localparam logic OP_MULT     = 1'b0;
    localparam logic OP_DIV      = 1'b1;
    localparam logic EXC_TIMEOUT = 1'b0;
    localparam logic EXC_DIV0    = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_reg, state_next;
    logic             op_reg, op_next;
    logic             exc_kind_reg, exc_kind_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cnt_expired;

    // The counter holds the number of WAIT cycles already spent, so the last
    // permitted WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign cnt_expired = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        exc_kind_next = exc_kind_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_mult) begin
                    state_next = MULT_INIT;
                    op_next    = OP_MULT;
                end else if (req_div) begin
                    state_next = DIV_INIT;
                    op_next    = OP_DIV;
                end
            end
            MULT_INIT: begin
                cnt_next   = '0;
                state_next = MULT_WAIT;
            end
            DIV_INIT: begin
                cnt_next   = '0;
                state_next = DIV_WAIT;
            end
            MULT_WAIT: begin
                if (mult_stop) begin
                    state_next = WRITE;
                end else if (cnt_expired) begin
                    state_next    = EXC;
                    exc_kind_next = EXC_TIMEOUT;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DIV_WAIT: begin
                // Divide-by-zero outranks a simultaneous result-valid.
                if (div_zero) begin
                    state_next    = EXC;
                    exc_kind_next = EXC_DIV0;
                end else if (div_stop) begin
                    state_next = WRITE;
                end else if (cnt_expired) begin
                    state_next    = EXC;
                    exc_kind_next = EXC_TIMEOUT;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            WRITE:   state_next = IDLE;
            EXC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_reg    <= IDLE;
            op_reg       <= OP_MULT;
            exc_kind_reg <= EXC_TIMEOUT;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            exc_kind_reg <= exc_kind_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Moore outputs; the mux selects follow op, which only changes on acceptance.
    assign mult_init    = (state_reg == MULT_INIT);
    assign div_init     = (state_reg == DIV_INIT);
    assign mux_high     = op_reg;
    assign mux_low      = op_reg;
    assign high_load    = (state_reg == WRITE);
    assign low_load     = (state_reg == WRITE);
    assign done         = (state_reg == WRITE);
    assign busy         = (state_reg != IDLE);
    assign div_zero_exc = (state_reg == EXC) && (exc_kind_reg == EXC_DIV0);
    assign timeout_exc  = (state_reg == EXC) && (exc_kind_reg == EXC_TIMEOUT);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus randomized transactions checked
// cycle by cycle against a per-transaction outcome model (finishing edge and result kind).
module tb_muldiv_sequencer;

    localparam int T      = 40;
    localparam int OUT_WR = 0;
    localparam int OUT_DZ = 1;
    localparam int OUT_TO = 2;

    logic clk      = 1'b0;
    logic reset_in = 1'b0;
    logic req_mult = 1'b0;
    logic req_div  = 1'b0;
    logic mult_stop = 1'b0;
    logic div_stop  = 1'b0;
    logic div_zero  = 1'b0;
    logic mult_init, div_init, mux_high, mux_low, high_load, low_load;
    logic busy, done, div_zero_exc, timeout_exc;

    int   vectors     = 0;
    int   miscompares = 0;
    logic last_op     = 1'b0;

    muldiv_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .req_mult     (req_mult),
        .req_div      (req_div),
        .mult_stop    (mult_stop),
        .div_stop     (div_stop),
        .div_zero     (div_zero),
        .mult_init    (mult_init),
        .div_init     (div_init),
        .mux_high     (mux_high),
        .mux_low      (mux_low),
        .high_load    (high_load),
        .low_load     (low_load),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs_vec();
        return {mult_init, div_init, mux_high, mux_low, high_load, low_load,
                busy, done, div_zero_exc, timeout_exc};
    endfunction

    // Outcome of one transaction: events count only on edges E2..E(T+1);
    // divide-by-zero wins ties, and any stop on the last edge beats the timeout.
    function automatic void predict(input bit is_div, input int sk, input int zk,
                                    output int f, output int outcome);
        bit s_ok = (sk >= 2) && (sk <= T + 1);
        bit z_ok = is_div && (zk >= 2) && (zk <= T + 1);
        f       = T + 1;
        outcome = OUT_TO;
        if (s_ok) begin
            f       = sk;
            outcome = OUT_WR;
        end
        if (z_ok && zk <= f) begin
            f       = zk;
            outcome = OUT_DZ;
        end
    endfunction

    // Expected outputs in cycle c (edge Ec..Ec+1) of a transaction finishing in cycle f.
    function automatic logic [9:0] exp_vec(input bit is_div, input int c, input int f,
                                           input int outcome);
        logic fin = (c == f);
        logic wr  = fin && (outcome == OUT_WR);
        return {(c == 0) && !is_div, (c == 0) && is_div, is_div, is_div, wr, wr,
                c <= f, wr, fin && (outcome == OUT_DZ), fin && (outcome == OUT_TO)};
    endfunction

    function automatic logic [9:0] idle_vec(input logic op);
        return {2'b00, op, op, 6'b000000};
    endfunction

    task automatic check(input logic [9:0] exp, input string tag, input int c);
        logic [9:0] obs = obs_vec();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    // One request followed by cycle-accurate checking until the sequencer is idle again.
    // Stray requests and irrelevant stop signals are sprinkled in while it is busy.
    task automatic txn(input bit rm, input bit rd, input int sk, input int zk, input string tag);
        bit is_div = !rm;
        int f, outcome;
        predict(is_div, sk, zk, f, outcome);
        req_mult = rm;
        req_div  = rd;
        for (int c = 0; c <= f + 1; c++) begin
            @(posedge clk);
            #1;
            check(exp_vec(is_div, c, f, outcome), tag, c);
            if (c <= f) begin
                mult_stop = is_div ? 1'($urandom_range(0, 1)) : 1'(c + 1 == sk);
                div_stop  = is_div ? 1'(c + 1 == sk) : 1'($urandom_range(0, 1));
                div_zero  = is_div ? 1'(c + 1 == zk) : 1'($urandom_range(0, 1));
                req_mult  = ($urandom_range(0, 3) == 0);
                req_div   = ($urandom_range(0, 3) == 0);
            end else begin
                mult_stop = 1'b0;
                div_stop  = 1'b0;
                div_zero  = 1'b0;
                req_mult  = 1'b0;
                req_div   = 1'b0;
            end
        end
        last_op = is_div;
    endtask

    task automatic idle(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            mult_stop = 1'($urandom_range(0, 1));
            div_stop  = 1'($urandom_range(0, 1));
            div_zero  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check(idle_vec(last_op), tag, c);
        end
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        div_zero  = 1'b0;
    endtask

    task automatic reset_mid(input bit is_div, input string tag);
        int f, outcome;
        predict(is_div, 0, 0, f, outcome);
        req_mult = !is_div;
        req_div  = is_div;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            req_mult = 1'b0;
            req_div  = 1'b0;
            check(exp_vec(is_div, c, f, outcome), tag, c);
        end
        #2 reset_in = 1'b0;
        #1 check(10'b0, "reset_async", 0);
        @(posedge clk);
        #1 check(10'b0, "reset_held", 0);
        reset_in = 1'b1;
        last_op  = 1'b0;
        @(posedge clk);
        #1 check(idle_vec(1'b0), "reset_release", 0);
        idle(2, "post_reset_idle");
    endtask

    initial begin
        @(posedge clk);
        #1 check(10'b0, "reset_state", 0);
        reset_in = 1'b1;
        idle(3, "idle_stray");

        txn(1'b1, 1'b0, 3, 0, "mult");
        txn(1'b0, 1'b1, 5, 0, "div");
        txn(1'b0, 1'b1, 2, 2, "div0_with_stop");
        txn(1'b1, 1'b0, 0, 0, "mult_timeout");
        txn(1'b0, 1'b1, 0, 0, "div_timeout");
        txn(1'b1, 1'b0, 40, 0, "stop_e40");
        txn(1'b1, 1'b0, T + 1, 0, "stop_last_wait");
        txn(1'b0, 1'b1, 0, T + 1, "div0_last_wait");
        txn(1'b1, 1'b0, T + 2, 0, "stop_too_late");
        txn(1'b1, 1'b1, 2, 2, "both_req");
        txn(1'b1, 1'b0, 1, 0, "stop_in_init");
        idle(1, "gap");

        reset_mid(1'b0, "rst_mid_mult");
        reset_mid(1'b1, "rst_mid_div");

        for (int i = 0; i < 60; i++) begin
            int kind = int'($urandom_range(0, 2));
            int sk   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8))
                                                   : int'($urandom_range(0, T + 4));
            int zsel = int'($urandom_range(0, 2));
            int zk   = (zsel == 0) ? sk : (zsel == 1) ? int'($urandom_range(1, 8)) : 0;
            txn(kind != 1, kind != 0, sk, zk, "random");
            idle(int'($urandom_range(0, 2)), "random_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer that sits between the multicycle control unit and the multiplier/divider datapath. It accepts one-cycle MULT/DIV requests, pulses the matching unit's init, and waits for completion with a bounded timeout. On success it loads HI/LO through the HI/LO source muxes; on failure it reports a division-by-zero or timeout exception. The control unit stalls on `busy` and vectors on the exception pulses.

## Interface
- `TIMEOUT_CYCLES`, 40: maximum number of WAIT cycles before a timeout exception.
- `CNT_W`, 6: counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

- `clk` in 1: system clock, rising edge.
- `reset_in` in 1: reset, asynchronous, active-low.
- `req_mult` in 1: start MULT. One-cycle pulse from the control unit.
- `req_div` in 1: start DIV. One-cycle pulse.
- `mult_stop` in 1: multiplier result valid.
- `div_stop` in 1: divider result valid.
- `div_zero` in 1: divider reports divisor == 0.
- `mult_init` out 1: one-cycle start pulse to the multiplier.
- `div_init` out 1: one-cycle start pulse to the divider.
- `mux_high` out 1: HI source select (0 = multiplier, 1 = divider).
- `mux_low` out 1: LO source select (0 = multiplier, 1 = divider).
- `high_load` out 1: HI register write enable.
- `low_load` out 1: LO register write enable.
- `busy` out 1: sequencer not idle.
- `done` out 1: one-cycle pulse, asserted in the same cycle HI/LO are loaded.
- `div_zero_exc` out 1: one-cycle division-by-zero exception pulse.
- `timeout_exc` out 1: one-cycle timeout exception pulse.

## Operation
- FSM states: IDLE, MULT_INIT, MULT_WAIT, DIV_INIT, DIV_WAIT, WRITE, EXC.
- All outputs are Moore-decoded from registered state, plus the `op` register and the `exc_kind` register.
- **IDLE**
  - Requests are sampled only in this state.
  - `req_mult` -> MULT_INIT with `op` = 0.
  - Otherwise `req_div` -> DIV_INIT with `op` = 1.
  - If both are high together, MULT wins and the DIV request is discarded.
- **MULT_INIT / DIV_INIT**
  - Assert the matching `*_init` for exactly one cycle.
  - Clear the counter.
  - Go to the matching WAIT state.
- **MULT_WAIT**
  - `mult_stop` -> WRITE.
  - Else, if counter == TIMEOUT_CYCLES-1 -> EXC with `exc_kind` = timeout.
  - Else increment the counter.
  - `div_stop` and `div_zero` are ignored in this state.
- **DIV_WAIT**
  - Priority order: `div_zero` -> EXC (`exc_kind` = div0), then `div_stop` -> WRITE, then the timeout check as in MULT_WAIT.
  - `mult_stop` is ignored in this state.
- **WRITE**
  - `high_load` = `low_load` = `done` = 1 for one cycle, then go to IDLE.
- **EXC**
  - Exactly one of `div_zero_exc` / `timeout_exc` = 1 for one cycle, then go to IDLE.
  - No HI/LO load occurs on any exception path.
- **Mux selects:** `mux_high` = `mux_low` = `op` at all times. `op` updates only on request acceptance, so the selects are stable from INIT through WRITE.
- **Busy and stray inputs**
  - `busy` = (state != IDLE).
  - Requests arriving while busy are dropped, not queued.
  - Stray `*_stop` or `div_zero` in IDLE has no effect.

## Timing
- **Reset:** `reset_in` low forces, immediately and asynchronously, state = IDLE, `op` = 0, counter = 0, `exc_kind` = 0. All outputs are 0.
- **Reset mid-operation:** aborts the operation with no HI/LO load and no exception pulse.
- **Request accepted at edge E0:**
  - INIT cycle is E0..E1 (`*_init` = 1).
  - WAIT states begin at E1.
- **Completion:**
  - Stop sampled high at edge Ek -> WRITE cycle Ek..Ek+1 -> IDLE at Ek+1.
  - Minimum request-to-load latency: load occurs in the cycle after E2 (stop seen in the first WAIT cycle).
- **Next request:** earliest accepted at edge Ek+2. A request at Ek+1 is lost because the state is not yet IDLE when sampled.
- **Timeout boundary:** the stop signal is honoured in all TIMEOUT_CYCLES WAIT cycles. A stop on the last cycle wins over the timeout.
- **Timeout latency:** with no stop, `timeout_exc` pulses in the cycle starting TIMEOUT_CYCLES+1 edges after E0.
- **div_zero vs div_stop:** if both arrive in the same cycle, `div_zero` wins.

## Test plan
- **Reset:** `reset_in` = 0 mid-MULT_WAIT -> all outputs drop to 0 immediately. After release, `busy` = 0 and `mux_high` = 0.
- **MULT:** `req_mult` pulse at E0, `mult_stop` high at E3 -> `mult_init` = 1 only in cycle E0..E1. `high_load` = `low_load` = `done` = 1 only in cycle E3..E4 with `mux_high` = `mux_low` = 0. `busy` = 0 after E4.
- **DIV:** `req_div` at E0, `div_stop` at E5 -> `div_init` pulses once. Loads with `mux_high` = `mux_low` = 1 in cycle E5..E6. `div_zero_exc` stays 0.
- **Divide by zero:** `req_div`, then `div_zero` and `div_stop` together at E2 -> `div_zero_exc` = 1 for one cycle. `high_load` = 0 throughout. Back to IDLE.
- **Timeout (TIMEOUT_CYCLES = 40):** `req_mult` at E0, no stop -> `timeout_exc` pulses in cycle E41..E42, no load. Separately, a stop at E40 -> normal WRITE and no timeout.
- **Conflicts:**
  - `req_mult` and `req_div` together -> MULT only.
  - `req_div` during MULT_WAIT -> ignored, no `div_init`.
  - `req_mult` at the edge leaving WRITE -> dropped.
  - `req_mult` one edge later -> accepted.
